mem_access_stage: RTL

Parametrised MEM stage of the 5-stage pipeline. It sits between the EX/MEM register and writeback and owns the MEM/WB pipeline register. It drives a data SRAM through a req/ack handshake that allows multi-cycle latency. It performs byte/half/full-width store lane steering and load extraction with sign or zero extension, detects misaligned accesses, and stalls upstream while a transaction is outstanding.

---
 rtl/mem_access_pkg.sv | 20 ++
 rtl/mem_lane_align.sv | 68 ++++++
 rtl/mem_access_stage.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM pipeline stage: access size codes, FSM states
// and the lane-offset width helper.
package mem_access_pkg;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_B    = 2'b01;
  localparam logic [1:0] SZ_H    = 2'b10;
  localparam logic [1:0] SZ_F    = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  // Number of address bits that select a byte lane within one SRAM word.
  function automatic int lane_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: store enable/data steering, load extract with
// sign/zero extension, and the misaligned-access flag.
module mem_lane_align
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [lane_bits(DATA_W)-1:0] lane,
  input  logic [1:0]                   size,
  input  logic                         load_unsigned,
  input  logic [DATA_W-1:0]            store_data,
  input  logic [DATA_W-1:0]            rdata,
  output logic [DATA_W/8-1:0]          wen,
  output logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            ld_data,
  output logic                         misaligned
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] shifted;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic              byte_sign;
  logic              half_sign;

  // Bring the addressed lane down to bit 0 so the extract is lane-independent.
  always_comb begin
    shifted   = rdata >> {lane, 3'b000};
    ld_byte   = shifted[7:0];
    ld_half   = shifted[15:0];
    byte_sign = ld_byte[7] & ~load_unsigned;
    half_sign = ld_half[15] & ~load_unsigned;
  end

  always_comb begin
    wen        = '0;
    wdata      = '0;
    ld_data    = '0;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        wen     = NB'(1) << lane;
        wdata   = {NB{store_data[7:0]}};
        ld_data = {{(DATA_W-8){byte_sign}}, ld_byte};
      end
      SZ_H: begin
        wen        = NB'(3) << lane;
        wdata      = {(NB/2){store_data[15:0]}};
        ld_data    = {{(DATA_W-16){half_sign}}, ld_half};
        misaligned = lane[0];
      end
      SZ_F: begin
        wen        = '1;
        wdata      = store_data;
        ld_data    = rdata;
        misaligned = |lane;
      end
      default: begin
        wen        = '0;
        wdata      = '0;
        ld_data    = '0;
        misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: data SRAM req/ack handshake with multi-cycle latency,
// address-error detection, upstream stall and the MEM/WB register.
module mem_access_stage
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RA_W   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic                flush,
  input  logic [1:0]          mem_read,
  input  logic [1:0]          mem_write,
  input  logic                load_unsigned,
  input  logic                branch,
  input  logic                zero,
  input  logic                mem_to_reg,
  input  logic                reg_write,
  input  logic [ADDR_W-1:0]   alu_out,
  input  logic [DATA_W-1:0]   store_data,
  input  logic [RA_W-1:0]     rd,
  output logic                data_sram_req,
  output logic                data_sram_wr,
  output logic [ADDR_W-1:0]   data_sram_addr,
  output logic [DATA_W/8-1:0] data_sram_wen,
  output logic [DATA_W-1:0]   data_sram_wdata,
  input  logic                data_sram_ack,
  input  logic [DATA_W-1:0]   data_sram_rdata,
  output logic                stall,
  output logic                br,
  output logic                wb_valid,
  output logic                wb_mem_to_reg,
  output logic                wb_reg_write,
  output logic [ADDR_W-1:0]   wb_alu_out,
  output logic [DATA_W-1:0]   wb_rdata,
  output logic [RA_W-1:0]     wb_rd,
  output logic                exc_adel,
  output logic                exc_ades,
  output logic [ADDR_W-1:0]   bad_vaddr
);

  localparam int OFF = lane_bits(DATA_W);
  localparam int NB  = DATA_W / 8;

  mem_state_e state_q, state_d;
  logic       drop_q, drop_d;

  logic              wb_valid_q, wb_valid_d;
  logic              wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic [ADDR_W-1:0] wb_alu_out_q, wb_alu_out_d;
  logic [DATA_W-1:0] wb_rdata_q, wb_rdata_d;
  logic [RA_W-1:0]   wb_rd_q, wb_rd_d;
  logic              exc_adel_q, exc_adel_d;
  logic              exc_ades_q, exc_ades_d;
  logic [ADDR_W-1:0] bad_vaddr_q, bad_vaddr_d;

  logic              is_load;
  logic              is_store;
  logic              memop;
  logic              aligned_op;
  logic [1:0]        size;
  logic [OFF-1:0]    lane;
  logic [NB-1:0]     lane_wen;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] ld_data;
  logic              misaligned;
  logic              req;
  logic              retire_alu;
  logic              retire_mem;
  logic              retire_exc;

  assign is_load    = (mem_read != SZ_NONE);
  assign is_store   = (mem_write != SZ_NONE);
  assign size       = is_store ? mem_write : mem_read;
  assign lane       = alu_out[OFF-1:0];
  assign memop      = in_valid & (is_load | is_store);
  assign aligned_op = memop & ~misaligned;

  mem_lane_align #(
    .DATA_W(DATA_W)
  ) u_lane_align (
    .lane         (lane),
    .size         (size),
    .load_unsigned(load_unsigned),
    .store_data   (store_data),
    .rdata        (data_sram_rdata),
    .wen          (lane_wen),
    .wdata        (lane_wdata),
    .ld_data      (ld_data),
    .misaligned   (misaligned)
  );

  // A request in flight cannot be cancelled, so a flush seen in WAIT only
  // marks the eventual completion to be discarded.
  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    req        = 1'b0;
    stall      = 1'b0;
    retire_alu = 1'b0;
    retire_mem = 1'b0;
    retire_exc = 1'b0;
    unique case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (aligned_op && !flush) begin
          req = 1'b1;
          if (data_sram_ack) begin
            retire_mem = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = WAIT;
          end
        end else if (in_valid && !flush) begin
          retire_exc = memop;
          retire_alu = ~memop;
        end
      end
      WAIT: begin
        req = 1'b1;
        if (data_sram_ack) begin
          state_d    = IDLE;
          drop_d     = 1'b0;
          retire_mem = ~(drop_q | flush);
        end else begin
          stall  = 1'b1;
          drop_d = drop_q | flush;
        end
      end
      default: begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end
    endcase
  end

  // Anything that does not retire loads a bubble; payload fields may hold.
  always_comb begin
    wb_valid_d      = 1'b0;
    wb_reg_write_d  = 1'b0;
    exc_adel_d      = 1'b0;
    exc_ades_d      = 1'b0;
    wb_mem_to_reg_d = wb_mem_to_reg_q;
    wb_alu_out_d    = wb_alu_out_q;
    wb_rdata_d      = wb_rdata_q;
    wb_rd_d         = wb_rd_q;
    bad_vaddr_d     = bad_vaddr_q;
    if (retire_alu || retire_mem || retire_exc) begin
      wb_valid_d      = 1'b1;
      wb_mem_to_reg_d = mem_to_reg;
      wb_alu_out_d    = alu_out;
      wb_rd_d         = rd;
      wb_reg_write_d  = reg_write & ~retire_exc;
    end
    if (retire_mem && is_load) begin
      wb_rdata_d = ld_data;
    end
    if (retire_exc) begin
      exc_adel_d  = is_load;
      exc_ades_d  = is_store;
      bad_vaddr_d = alu_out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      drop_q          <= 1'b0;
      wb_valid_q      <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_alu_out_q    <= '0;
      wb_rdata_q      <= '0;
      wb_rd_q         <= '0;
      exc_adel_q      <= 1'b0;
      exc_ades_q      <= 1'b0;
      bad_vaddr_q     <= '0;
    end else begin
      state_q         <= state_d;
      drop_q          <= drop_d;
      wb_valid_q      <= wb_valid_d;
      wb_mem_to_reg_q <= wb_mem_to_reg_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_alu_out_q    <= wb_alu_out_d;
      wb_rdata_q      <= wb_rdata_d;
      wb_rd_q         <= wb_rd_d;
      exc_adel_q      <= exc_adel_d;
      exc_ades_q      <= exc_ades_d;
      bad_vaddr_q     <= bad_vaddr_d;
    end
  end

  // SRAM-side outputs are forced quiet whenever no request is being made.
  assign data_sram_req   = req;
  assign data_sram_wr    = req & is_store;
  assign data_sram_addr  = req ? {alu_out[ADDR_W-1:OFF], {OFF{1'b0}}} : '0;
  assign data_sram_wen   = (req && is_store) ? lane_wen : '0;
  assign data_sram_wdata = (req && is_store) ? lane_wdata : '0;

  assign br            = branch & zero & ~reset;
  assign wb_valid      = wb_valid_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_alu_out    = wb_alu_out_q;
  assign wb_rdata      = wb_rdata_q;
  assign wb_rd         = wb_rd_q;
  assign exc_adel      = exc_adel_q;
  assign exc_ades      = exc_ades_q;
  assign bad_vaddr     = bad_vaddr_q;

endmodule
